enemy_spawner: RTL and testbench
================================

Name: enemy_spawner

Overview:
Game-logic controller driving a bank of Enemy car instances: launches and retires cars, assigns lanes, detects player/enemy overlap and drives the shared collision freeze.
- Sits between the top-level game FSM and the Enemy instances, on logic_clk.
- It is the command side of the Enemy interface: drives offset_x, offset_y, enable and collision; consumes pos_x and pos_y.

Parameters:
NUM_ENEMIES, 3, number of Enemy slots managed
SPAWN_GAP, 150, logic_clk ticks between spawn attempts
MIN_GAP, 40, floor for spawn gap (ramp feature only)
CAR_W, 80, car sprite width in pixels
CAR_H, 121, car sprite height in pixels
LFSR_SEED, 16'hACE1, lane-select LFSR reset value

Ports:
logic_clk  in  1  game tick clock
reset  in  1  synchronous, active-high
start  in  1  one-tick pulse: IDLE->RUN, or CRASH->IDLE
player_x  in  10  player car left edge
player_y  in  10  player car top edge
enemy_pos_x  in  10*NUM_ENEMIES  pos_x of each Enemy, slot i at [10i+9:10i]
enemy_pos_y  in  10*NUM_ENEMIES  pos_y of each Enemy
enemy_offset_x  out  10*NUM_ENEMIES  lane X per slot
enemy_offset_y  out  10*NUM_ENEMIES  ARM_Y (610) = descend, PARK_Y (620) = parked
enemy_enable  out  NUM_ENEMIES  per-slot enable
collision  out  1  freeze to all Enemy instances and to the game FSM
score  out  16  cars survived
game_state  out  2  IDLE=0, RUN=1, CRASH=2

Behaviour:
Reset state (all outputs registered):
- State IDLE; all slots free.
- enemy_offset_y = PARK_Y, enemy_enable = 0, enemy_offset_x = LANE_X[0].
- collision = 0, score = 0, spawn timer = 0, LFSR = LFSR_SEED.
- A reset asserted mid-game takes effect on the next edge and overrides every other event.

IDLE:
- Outputs held at reset values.
- start -> RUN; clears score and spawn timer.

RUN:
- LFSR (x^16+x^14+x^13+x^11) advances every tick.
- Spawn timer increments; when it reaches the current gap, attempt a spawn.
- Lane select = lfsr[1:0]:
  - 0/1/2 -> LANE_X = 160/280/400.
  - 3 -> no spawn this tick; retry next tick with the timer held at gap.
- If no slot is free, also hold the timer at gap and retry.
- Successful spawn, into the lowest-index free slot:
  - offset_x = lane, offset_y = ARM_Y, enable = 1, slot marked active.
  - Timer cleared.
  - Effective on the next edge.
- Retire: an active slot whose enemy_pos_y == 600 is retired on the next edge (offset_y = PARK_Y, enable = 0, slot freed), and score increments by 1.
  - Score wraps at 16'hFFFF -> 0.
- Retire and spawn on the same tick are allowed. A slot being retired is not free for that tick's spawn.

Collision check (combinational compare, registered result; 1-tick latency):
- Evaluated per active slot with enemy_pos_y < 480.
- Overlap when |player_x - enemy_pos_x| < CAR_W AND |player_y - enemy_pos_y| < CAR_H.
- Use 11-bit signed differences; no wrap.
- Any overlap -> collision = 1 and transition to CRASH on the same edge.
- If overlap and retire happen on the same tick, collision wins: no score increment and no retire.

CRASH:
- collision held at 1; slots keep their offsets and enables, so Enemy cars stay frozen.
- Spawn timer and LFSR frozen; score frozen.
- start -> IDLE: collision = 0, all slots parked and freed.

Optional Feature:
DIFFICULTY_RAMP_EN
- Defined: the gap starts at SPAWN_GAP and drops by 8 each time score crosses a multiple of 8.
  - Saturates at MIN_GAP.
  - Resets to SPAWN_GAP on entering RUN.
- Undefined: the gap is the constant SPAWN_GAP, and MIN_GAP is unused.

Decomposition:
- Package race_pkg holds:
  - LANE_X[3] = {160, 280, 400}
  - ARM_Y = 610, PARK_Y = 620, SCREEN_BOTTOM = 600, VISIBLE_H = 480
  - game_state_t enum {IDLE, RUN, CRASH}
- Sub-module lfsr16 (enable, seed, 16-bit state out) is the natural split. It is reusable by the road and stripe generators.

Test Plan:
- Reset, then start -> game_state = 1. After 150 ticks, if lfsr[1:0] != 3: slot 0 offset_y = 610, enable[0] = 1, offset_x within {160, 280, 400}.
- Force enemy_pos_y[slot0] = 600 for 1 tick -> next tick enable[0] = 0, offset_y[0] = 620, score = 1.
- All 3 slots active, timer at gap -> no spawn; timer holds at 150 until a retire frees a slot, then spawn in the following tick.
- player = (200, 350), enemy slot1 pos = (160, 300) active -> collision = 1 and game_state = 2 after 1 tick. Slot1 pos_y = 600 in the same tick -> score unchanged.
- In CRASH, pulse start -> collision = 0, all enable = 0, offsets = 620, game_state = 0. Next start clears score to 0.
- Reset asserted in RUN with 2 active slots -> next tick all outputs at reset values, LFSR = 16'hACE1. With DIFFICULTY_RAMP_EN defined, score 8 -> gap = 142, and the gap never falls below 40.

Source files
------------

// File: rtl/race_pkg.sv
// Shared constants and types for the race game logic.
// Lane geometry, screen limits and the top-level game state encoding.
package race_pkg;

  localparam logic [9:0] ARM_Y         = 10'd610;
  localparam logic [9:0] PARK_Y        = 10'd620;
  localparam logic [9:0] SCREEN_BOTTOM = 10'd600;
  localparam logic [9:0] VISIBLE_H     = 10'd480;

  localparam logic [9:0] LANE_X [3] = '{10'd160, 10'd280, 10'd400};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2
  } game_state_t;

  // Code 3 has no lane; callers treat it as "skip this tick".
  function automatic logic [9:0] lane_x(input logic [1:0] sel);
    case (sel)
      2'd1:    return LANE_X[1];
      2'd2:    return LANE_X[2];
      default: return LANE_X[0];
    endcase
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11.
// Loads seed on reset and shifts left while enable is high.
module lfsr16 (
  input  logic        logic_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic fb;

  assign fb = state[15] ^ state[13] ^ state[12] ^ state[10];

  always_ff @(posedge logic_clk) begin
    if (reset)
      state <= seed;
    else if (enable)
      state <= {state[14:0], fb};
  end

endmodule

// File: rtl/enemy_spawner.sv
// Enemy car launcher/retirer with player collision freeze.
// Define DIFFICULTY_RAMP_EN to shrink the spawn gap as the score rises.
module enemy_spawner
  import race_pkg::*;
#(
  parameter int          NUM_ENEMIES = 3,
  parameter int          SPAWN_GAP   = 150,
  parameter int          MIN_GAP     = 40,
  parameter int          CAR_W       = 80,
  parameter int          CAR_H       = 121,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                      logic_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [9:0]                player_x,
  input  logic [9:0]                player_y,
  input  logic [10*NUM_ENEMIES-1:0] enemy_pos_x,
  input  logic [10*NUM_ENEMIES-1:0] enemy_pos_y,
  output logic [10*NUM_ENEMIES-1:0] enemy_offset_x,
  output logic [10*NUM_ENEMIES-1:0] enemy_offset_y,
  output logic [NUM_ENEMIES-1:0]    enemy_enable,
  output logic                      collision,
  output logic [15:0]               score,
  output logic [1:0]                game_state
);

  localparam logic [15:0]        GAP0 = 16'(SPAWN_GAP);
  localparam logic signed [10:0] W    = 11'(CAR_W);
  localparam logic signed [10:0] H    = 11'(CAR_H);

  game_state_t state_q, state_d;

  logic [15:0] lfsr;
  logic [15:0] timer_q;
  logic [15:0] gap;
  logic [15:0] retire_cnt;
  logic [15:0] score_nx;
  logic        run;
  logic        overlap;
  logic        attempt;
  logic        spawn;
  logic        any_free;
  logic [9:0]  lane;

  logic [NUM_ENEMIES-1:0] retire;
  logic [NUM_ENEMIES-1:0] hit;
  logic [NUM_ENEMIES-1:0] spawn_sel;
  logic signed [10:0]     dx;
  logic signed [10:0]     dy;

  assign run        = (state_q == RUN);
  assign game_state = state_q;

  lfsr16 u_lfsr (
    .logic_clk (logic_clk),
    .reset     (reset),
    .enable    (run),
    .seed      (LFSR_SEED),
    .state     (lfsr)
  );

  // Only parked slots are free, so a slot retiring this tick is skipped.
  always_comb begin
    retire     = '0;
    hit        = '0;
    spawn_sel  = '0;
    any_free   = 1'b0;
    retire_cnt = '0;
    dx         = '0;
    dy         = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      dx = $signed({1'b0, player_x}) - $signed({1'b0, enemy_pos_x[10*i +: 10]});
      dy = $signed({1'b0, player_y}) - $signed({1'b0, enemy_pos_y[10*i +: 10]});
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      retire[i] = enemy_enable[i] &&
                  (enemy_pos_y[10*i +: 10] == SCREEN_BOTTOM);
      hit[i]    = enemy_enable[i] &&
                  (enemy_pos_y[10*i +: 10] < VISIBLE_H) &&
                  (dx < W) && (dy < H);
      if (!enemy_enable[i] && !any_free) begin
        spawn_sel[i] = 1'b1;
        any_free     = 1'b1;
      end
      retire_cnt = retire_cnt + 16'(retire[i]);
    end
  end

  assign overlap  = |hit;
  assign attempt  = (timer_q >= gap);
  assign spawn    = attempt && (lfsr[1:0] != 2'd3) && any_free;
  assign lane     = lane_x(lfsr[1:0]);
  assign score_nx = score + retire_cnt;

  always_ff @(posedge logic_clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (overlap) state_d = CRASH;
      CRASH:   if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (reset) begin
      collision    <= 1'b0;
      score        <= '0;
      timer_q      <= '0;
      enemy_enable <= '0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        enemy_offset_x[10*i +: 10] <= lane_x(2'd0);
        enemy_offset_y[10*i +: 10] <= PARK_Y;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            score   <= '0;
            timer_q <= '0;
          end
        end
        RUN: begin
          // A crash freezes the board exactly as it stood.
          if (overlap) begin
            collision <= 1'b1;
          end else begin
            score <= score_nx;
            if (!attempt)
              timer_q <= timer_q + 16'd1;
            else if (spawn)
              timer_q <= '0;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
              if (retire[i]) begin
                enemy_enable[i]            <= 1'b0;
                enemy_offset_y[10*i +: 10] <= PARK_Y;
              end else if (spawn && spawn_sel[i]) begin
                enemy_enable[i]            <= 1'b1;
                enemy_offset_x[10*i +: 10] <= lane;
                enemy_offset_y[10*i +: 10] <= ARM_Y;
              end
            end
          end
        end
        CRASH: begin
          if (start) begin
            collision    <= 1'b0;
            enemy_enable <= '0;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
              enemy_offset_x[10*i +: 10] <= lane_x(2'd0);
              enemy_offset_y[10*i +: 10] <= PARK_Y;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIFFICULTY_RAMP_EN
  logic cross;
  logic unused_bits;

  assign cross       = (score_nx[15:3] != score[15:3]);
  assign unused_bits = ^{lfsr[15:2], score_nx[2:0]};

  always_ff @(posedge logic_clk) begin
    if (reset)
      gap <= GAP0;
    else if ((state_q == IDLE) && start)
      gap <= GAP0;
    else if (run && !overlap && cross)
      gap <= (gap >= 16'(MIN_GAP) + 16'd8) ? gap - 16'd8 : 16'(MIN_GAP);
  end
`else
  logic unused_bits;

  assign gap         = GAP0;
  assign unused_bits = ^{lfsr[15:2], 16'(MIN_GAP)};
`endif

endmodule

// File: tb/tb_enemy_spawner.sv
// Randomized bench for enemy_spawner against a behavioural game model.
// Honours DIFFICULTY_RAMP_EN in the model when the macro is defined.
module tb_enemy_spawner;

  localparam int N      = 3;
  localparam int GAP    = 150;
  localparam int CYCLES = 6000;

  logic          logic_clk = 1'b0;
  logic          reset;
  logic          start;
  logic [9:0]    player_x;
  logic [9:0]    player_y;
  logic [10*N-1:0] enemy_pos_x;
  logic [10*N-1:0] enemy_pos_y;
  logic [10*N-1:0] enemy_offset_x;
  logic [10*N-1:0] enemy_offset_y;
  logic [N-1:0]  enemy_enable;
  logic          collision;
  logic [15:0]   score;
  logic [1:0]    game_state;

  enemy_spawner dut (
    .logic_clk      (logic_clk),
    .reset          (reset),
    .start          (start),
    .player_x       (player_x),
    .player_y       (player_y),
    .enemy_pos_x    (enemy_pos_x),
    .enemy_pos_y    (enemy_pos_y),
    .enemy_offset_x (enemy_offset_x),
    .enemy_offset_y (enemy_offset_y),
    .enemy_enable   (enemy_enable),
    .collision      (collision),
    .score          (score),
    .game_state     (game_state)
  );

  always #5 logic_clk = ~logic_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Game model: 0 idle, 1 running, 2 crashed.
  int          m_state, m_score, m_timer, m_gap;
  logic [15:0] m_lfsr;
  bit          m_coll;
  bit          m_en [N];
  int          m_ox [N];
  int          m_oy [N];
  int          lanes [3] = '{160, 280, 400};

  int px, py;
  int ex [N];
  int ey [N];

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clamp10(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_score = 0;
    m_timer = 0;
    m_gap   = GAP;
    m_lfsr  = 16'hACE1;
    m_coll  = 0;
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0;
      m_ox[i] = 160;
      m_oy[i] = 620;
    end
  endtask

  task automatic model_tick(input bit st);
    bit hit;
    bit ret [N];
    int first_free;
    int cnt;
    int old;
    hit = 0;
    first_free = -1;
    cnt = 0;
    case (m_state)
      0: begin
        if (st) begin
          m_state = 1;
          m_score = 0;
          m_timer = 0;
          m_gap   = GAP;
        end
      end
      1: begin
        for (int i = 0; i < N; i++)
          if (m_en[i] && ey[i] < 480 && iabs(px - ex[i]) < 80 &&
              iabs(py - ey[i]) < 121)
            hit = 1;
        if (hit) begin
          m_coll  = 1;
          m_state = 2;
        end else begin
          for (int i = 0; i < N; i++) begin
            ret[i] = m_en[i] && ey[i] == 600;
            if (ret[i]) cnt++;
            if (!m_en[i] && first_free < 0) first_free = i;
          end
          for (int i = 0; i < N; i++)
            if (ret[i]) begin
              m_en[i] = 0;
              m_oy[i] = 620;
            end
          if (m_timer >= m_gap) begin
            if ((m_lfsr % 4) != 3 && first_free >= 0) begin
              m_en[first_free] = 1;
              m_ox[first_free] = lanes[m_lfsr % 4];
              m_oy[first_free] = 610;
              m_timer = 0;
            end
          end else begin
            m_timer++;
          end
          old = m_score;
          m_score = (m_score + cnt) % 65536;
`ifdef DIFFICULTY_RAMP_EN
          if (m_score / 8 != old / 8)
            m_gap = (m_gap - 8 < 40) ? 40 : m_gap - 8;
`else
          old = old;
`endif
        end
        m_lfsr = lfsr_next(m_lfsr);
      end
      default: begin
        if (st) begin
          m_state = 0;
          m_coll  = 0;
          for (int i = 0; i < N; i++) begin
            m_en[i] = 0;
            m_ox[i] = 160;
            m_oy[i] = 620;
          end
        end
      end
    endcase
  endtask

  task automatic compare(input int cyc);
    check($sformatf("state@%0d", cyc), 32'(game_state), 32'(m_state));
    check($sformatf("coll@%0d", cyc), 32'(collision), 32'(m_coll));
    check($sformatf("score@%0d", cyc), 32'(score), 32'(m_score));
    for (int i = 0; i < N; i++) begin
      check($sformatf("en%0d@%0d", i, cyc), 32'(enemy_enable[i]),
            32'(m_en[i]));
      check($sformatf("ox%0d@%0d", i, cyc),
            32'(enemy_offset_x[10*i +: 10]), 32'(m_ox[i]));
      check($sformatf("oy%0d@%0d", i, cyc),
            32'(enemy_offset_y[10*i +: 10]), 32'(m_oy[i]));
    end
  endtask

  task automatic pick_inputs();
    int k;
    bit near;
    k = -1;
    near = ($urandom_range(0, 79) == 0);
    if (near)
      for (int i = 0; i < N; i++)
        if (m_en[i] && k < 0) k = i;
    px = $urandom_range(560, 639);
    py = $urandom_range(0, 479);
    for (int i = 0; i < N; i++) begin
      ex[i] = m_en[i] ? m_ox[i] : $urandom_range(0, 639);
      if (m_en[i])
        ey[i] = ($urandom_range(0, 299) == 0) ? 600 : $urandom_range(0, 599);
      else
        ey[i] = $urandom_range(0, 620);
    end
    if (k >= 0) begin
      ey[k] = $urandom_range(0, 479);
      px = clamp10(ex[k] + $urandom_range(0, 200) - 100);
      py = clamp10(ey[k] + $urandom_range(0, 300) - 150);
      for (int i = 0; i < N; i++)
        if (i != k && m_en[i] && $urandom_range(0, 1) == 1) ey[i] = 600;
    end
    player_x = 10'(px);
    player_y = 10'(py);
    for (int i = 0; i < N; i++) begin
      enemy_pos_x[10*i +: 10] = 10'(ex[i]);
      enemy_pos_y[10*i +: 10] = 10'(ey[i]);
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    player_x    = '0;
    player_y    = '0;
    enemy_pos_x = '0;
    enemy_pos_y = '0;
    model_reset();
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge logic_clk);
      pick_inputs();
      reset = (cyc < 2) || (cyc == 3000) || ($urandom_range(0, 1499) == 0);
      start = ($urandom_range(0, 9) == 0);
      if (reset)
        model_reset();
      else
        model_tick(start);
      @(posedge logic_clk);
      #1;
      compare(cyc);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
